// File: rtl/bcp_imply_fifo_pkg.sv
// Shared literal types and sizing for the BCP processing element.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcp_pkg;

  localparam int LIT_INDEX_MAX = 1024;
  localparam int CLA_LENGTH    = 3;
  // One extra bit so that a variable index can carry its polarity as a sign.
  localparam int LIT_W         = $clog2(LIT_INDEX_MAX) + 1;

  // Signed literal: +v / -v for variable v, 0 means "no literal".
  typedef logic signed [LIT_W-1:0] lit_t;

endpackage

// File: rtl/bcp_imply_fifo_if.sv
// Handshake bundle between the PE, the implied-literal FIFO and its consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry backpressure in each direction.
interface bcp_imply_fifo_if;
  import bcp_pkg::*;

  // PE result side
  logic in_valid;
  logic in_ready;
  logic in_imply;
  lit_t in_lit;
  logic in_confl;

  // Propagation-literal consumer side
  logic out_valid;
  logic out_ready;
  lit_t out_lit;

  // Producer/consumer view (testbench or surrounding logic)
  modport master (
    output in_valid, in_imply, in_lit, in_confl, out_ready,
    input  in_ready, out_valid, out_lit
  );

  // FIFO view
  modport slave (
    input  in_valid, in_imply, in_lit, in_confl, out_ready,
    output in_ready, out_valid, out_lit
  );

endinterface

// File: rtl/bcp_imply_fifo_cam.sv
// Combinational match of a candidate literal against all live FIFO entries (BCP_IMPLY_DEDUP_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides what to do with the hit flags.
`ifdef BCP_IMPLY_DEDUP_EN
module bcp_imply_cam
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  lit_t             entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  lit_t             key_i,
  output logic             hit_pos_o,
  output logic             hit_neg_o
);

  lit_t neg_key;

  // Negation wraps within LIT_W, so the most negative literal maps to itself.
  assign neg_key = -key_i;

  // Scan every live entry for the same or the complementary literal.
  always_comb begin
    hit_pos_o = 1'b0;
    hit_neg_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i]) begin
        if (entries_i[i] == key_i)   hit_pos_o = 1'b1;
        if (entries_i[i] == neg_key) hit_neg_o = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/bcp_imply_fifo.sv
// Buffers implied literals from the BCP PE and returns them in order; sticky conflict flag.
// Latency: 1 cycle push-to-head, no bypass; optional dedup via BCP_IMPLY_DEDUP_EN.
// Backpressure: in_ready drops only when full and not in conflict; conflict drains input silently.
module bcp_imply_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  bcp_imply_fifo_if.slave            io,
  output logic                       conflict,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  lit_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             conflict_q, conflict_d;

  logic full;
  logic in_ready;
  logic out_valid;
  logic accept;
  logic candidate;
  logic push;
  logic pop;
  logic hit_pos;
  logic hit_neg;

  assign full      = (count_q == CNT_W'(DEPTH));
  // While in conflict the stage swallows everything so the PE never stalls.
  assign in_ready  = !full || conflict_q;
  // Entries survive a conflict but are hidden from the consumer.
  assign out_valid = (count_q != '0) && !conflict_q;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_lit   = out_valid ? mem_q[rd_ptr_q] : '0;

  assign accept    = io.in_valid && in_ready;
  assign candidate = accept && io.in_imply && (io.in_lit != '0) && !conflict_q;
  assign pop       = out_valid && io.out_ready;

`ifdef BCP_IMPLY_DEDUP_EN
  logic [DEPTH-1:0] live_mask;

  // An entry is live when its distance from the read pointer is below count,
  // which keeps the head visible to the compare even while it is popping.
  always_comb begin
    logic [PTR_W-1:0] offs;
    offs      = '0;
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PTR_W'(i) - rd_ptr_q;
      live_mask[i] = ({1'b0, offs} < count_q);
    end
  end

  bcp_imply_cam #(
    .DEPTH (DEPTH)
  ) u_cam (
    .entries_i (mem_q),
    .valid_i   (live_mask),
    .key_i     (io.in_lit),
    .hit_pos_o (hit_pos),
    .hit_neg_o (hit_neg)
  );
`else
  assign hit_pos = 1'b0;
  assign hit_neg = 1'b0;
`endif

  // Duplicates are dropped; a complementary literal is a conflict, never stored.
  assign push = candidate && !hit_pos && !hit_neg;

  // Next-state for pointers, occupancy and the sticky conflict; flush overrides all.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    conflict_d = conflict_q || (accept && io.in_confl) || (candidate && hit_neg);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      conflict_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
    end
  end

  // Literal storage; contents need no reset because out_lit is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[wr_ptr_q] <= io.in_lit;
    end
  end

  assign conflict = conflict_q;
  assign count    = count_q;

endmodule

// File: tb/tb_bcp_imply_fifo.sv
// Self-checking bench for bcp_imply_fifo against a queue-based reference model.
// Latency: checks outputs each cycle #1 after the falling edge, before the next rising edge.
// Backpressure: exercises full, conflict drain, flush and mid-stream reset.
module tb_bcp_imply_fifo;
  import bcp_pkg::*;

  localparam int DEPTH = 16;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       conflict;
  logic [$clog2(DEPTH+1)-1:0] count;

  bcp_imply_fifo_if io ();

  bcp_imply_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .io       (io),
    .conflict (conflict),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: ordered list of held literals plus the sticky conflict bit.
  lit_t mq[$];
  bit   m_conf;

  function automatic void model_step();
    int   sz;
    bit   ready, accept, pop, cand, dropped, new_conf;
    lit_t nk;
    sz      = mq.size();
    dropped = 0;
    if (rst || flush) begin
      mq.delete();
      m_conf = 0;
      return;
    end
    ready    = (sz != DEPTH) || m_conf;
    accept   = io.in_valid && ready;
    pop      = (sz != 0) && !m_conf && io.out_ready;
    new_conf = m_conf || (accept && io.in_confl);
    cand     = accept && io.in_imply && (io.in_lit != 0) && !m_conf;
`ifdef BCP_IMPLY_DEDUP_EN
    nk = -io.in_lit;
    if (cand) begin
      foreach (mq[k]) begin
        if (mq[k] == io.in_lit) dropped = 1;
        if (mq[k] == nk) begin
          dropped  = 1;
          new_conf = 1;
        end
      end
    end
`else
    nk = '0;
    if (nk != '0) dropped = 1;
`endif
    if (pop) void'(mq.pop_front());
    if (cand && !dropped) mq.push_back(io.in_lit);
    m_conf = new_conf;
  endfunction

  task automatic drive(input logic f, input logic v, input logic imp, input lit_t lit,
                       input logic cf, input logic ordy);
    @(negedge clk);
    flush        = f;
    io.in_valid  = v;
    io.in_imply  = imp;
    io.in_lit    = lit;
    io.in_confl  = cf;
    io.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== '0)         begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (io.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
    n_vec++; if (io.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
    n_vec++; if (io.out_lit !== '0)     begin n_err++; $display("FAIL reset_out_lit got %0d want 0", io.out_lit); end
    n_vec++; if (conflict !== 1'b0)     begin n_err++; $display("FAIL reset_conflict got %b want 0", conflict); end
  endtask

  task automatic test_order();
    lit_t exp_l [3];
    exp_l = '{lit_t'(5), lit_t'(-7), lit_t'(9)};
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, exp_l[k], 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== 5'd3) begin n_err++; $display("FAIL order_count got %0d want 3", count); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      n_vec++; if (io.out_valid !== 1'b1) begin n_err++; $display("FAIL order_valid[%0d] got %b want 1", k, io.out_valid); end
      n_vec++; if (io.out_lit !== exp_l[k]) begin n_err++; $display("FAIL order_lit[%0d] got %0d want %0d", k, io.out_lit, exp_l[k]); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 1);
    n_vec++; if (io.out_valid !== 1'b0) begin n_err++; $display("FAIL order_drained got %b want 0", io.out_valid); end
    tick();
  endtask

  task automatic test_full_wrap();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 1, lit_t'(i + 1), 0, 0);
      n_vec++; if (io.in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %b want 1", i, io.in_ready); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL full_count got %0d want 16", count); end
    n_vec++; if (io.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", io.in_ready); end
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 1, lit_t'(DEPTH + 1 + i), 0, 1);
      n_vec++; if (io.out_lit !== mq[0]) begin n_err++; $display("FAIL wrap_lit[%0d] got %0d want %0d", i, io.out_lit, mq[0]); end
      n_vec++; if (int'(count) !== mq.size()) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, mq.size()); end
      tick();
    end
  endtask

  task automatic test_nonqual_conflict();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 20, 0, 0); tick();
    drive(0, 1, 1, 21, 0, 0); tick();
    drive(0, 1, 0, 33, 0, 0);
    n_vec++; if (io.in_ready !== 1'b1) begin n_err++; $display("FAIL noimply_ready got %b want 1", io.in_ready); end
    tick();
    drive(0, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== 5'd2) begin n_err++; $display("FAIL nonqual_count got %0d want 2", count); end
    drive(0, 1, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1);
    n_vec++; if (conflict !== 1'b1)     begin n_err++; $display("FAIL confl_set got %b want 1", conflict); end
    n_vec++; if (io.out_valid !== 1'b0) begin n_err++; $display("FAIL confl_hidden got %b want 0", io.out_valid); end
    n_vec++; if (io.in_ready !== 1'b1)  begin n_err++; $display("FAIL confl_ready got %b want 1", io.in_ready); end
    n_vec++; if (count !== 5'd2)        begin n_err++; $display("FAIL confl_retained got %0d want 2", count); end
    drive(1, 1, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (conflict !== 1'b0) begin n_err++; $display("FAIL flush_confl got %b want 0", conflict); end
    n_vec++; if (count !== '0)      begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
  endtask

  task automatic test_dedup();
    logic [4:0] want_cnt;
    logic       want_cf;
`ifdef BCP_IMPLY_DEDUP_EN
    want_cnt = 5'd1; want_cf = 1'b1;
`else
    want_cnt = 5'd3; want_cf = 1'b0;
`endif
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 12, 0, 0); tick();
    drive(0, 1, 1, 12, 0, 0); tick();
    drive(0, 1, 1, -12, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== want_cnt)   begin n_err++; $display("FAIL dedup_count got %0d want %0d", count, want_cnt); end
    n_vec++; if (conflict !== want_cf) begin n_err++; $display("FAIL dedup_conflict got %b want %b", conflict, want_cf); end
  endtask

  task automatic test_pop_push_same();
    logic [4:0] want_cnt;
`ifdef BCP_IMPLY_DEDUP_EN
    want_cnt = 5'd0;
`else
    want_cnt = 5'd1;
`endif
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 3, 0, 0); tick();
    drive(0, 1, 1, 3, 0, 1);
    n_vec++; if (io.out_lit !== lit_t'(3)) begin n_err++; $display("FAIL pp_head got %0d want 3", io.out_lit); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== want_cnt) begin n_err++; $display("FAIL pp_count got %0d want %0d", count, want_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, lit_t'(100 + i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== 5'd5) begin n_err++; $display("FAIL mid_pre_count got %0d want 5", count); end
    drive(0, 1, 1, 77, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (count !== '0)          begin n_err++; $display("FAIL mid_count got %0d want 0", count); end
    n_vec++; if (io.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", io.out_valid); end
    n_vec++; if (conflict !== 1'b0)     begin n_err++; $display("FAIL mid_conflict got %b want 0", conflict); end
    n_vec++; if (io.in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_ready got %b want 1", io.in_ready); end
  endtask

  task automatic test_random();
    lit_t exp_lit;
    logic f, v, imp, cf, ordy;
    lit_t lit;
    for (int c = 0; c < 1200; c++) begin
      f    = ($urandom_range(39) == 0);
      v    = ($urandom_range(3) != 0);
      imp  = ($urandom_range(4) != 0);
      lit  = lit_t'(int'($urandom_range(40)) - 20);
      cf   = ($urandom_range(59) == 0);
      ordy = ($urandom_range(3) < ((c % 400) < 200 ? 1 : 3));
      drive(f, v, imp, lit, cf, ordy);
      exp_lit = (mq.size() != 0 && !m_conf) ? mq[0] : lit_t'(0);
      n_vec++; if (int'(count) !== mq.size()) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, count, mq.size()); end
      n_vec++; if (conflict !== m_conf) begin n_err++; $display("FAIL rnd_conflict[%0d] got %b want %b", c, conflict, m_conf); end
      n_vec++; if (io.out_valid !== (mq.size() != 0 && !m_conf)) begin n_err++; $display("FAIL rnd_valid[%0d] got %b", c, io.out_valid); end
      n_vec++; if (io.in_ready !== (mq.size() != DEPTH || m_conf)) begin n_err++; $display("FAIL rnd_ready[%0d] got %b", c, io.in_ready); end
      n_vec++; if (io.out_lit !== exp_lit) begin n_err++; $display("FAIL rnd_lit[%0d] got %0d want %0d", c, io.out_lit, exp_lit); end
      tick();
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_imply  = 1'b0;
    io.in_lit    = '0;
    io.in_confl  = 1'b0;
    io.out_ready = 1'b0;
    m_conf       = 0;
    test_reset();
    test_order();
    test_full_wrap();
    test_nonqual_conflict();
    test_dedup();
    test_pop_push_same();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
